// File: rtl/block_renderer_pkg.sv
// ============================================================================
// Module : block_renderer_pkg
// Brief  : Screen geometry, colour width and coordinate types shared with the
//          position registers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package block_renderer_pkg;

   localparam int X_SCREEN = 160;
   localparam int Y_SCREEN = 120;
   localparam int X_MAX    = 144;
   localparam int COLOUR_W = 3;

   localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

   typedef logic [7:0]          xcoord_t;
   typedef logic [6:0]          ycoord_t;
   typedef logic [COLOUR_W-1:0] colour_t;

   // Column sum carries a ninth bit so off-screen columns are detectable.
   function automatic logic [8:0] col_sum(input xcoord_t base, input xcoord_t ofs);
      return {1'b0, base} + {1'b0, ofs};
   endfunction

endpackage

`default_nettype wire

// File: rtl/block_renderer_if.sv
// ============================================================================
// Module : block_renderer_if
// Brief  : Redraw request, VGA plot port and status of the block renderer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface block_renderer_if;
   import block_renderer_pkg::*;

   logic    start;
   xcoord_t x_position;
   ycoord_t y_position;
   xcoord_t width;
   colour_t colour;

   xcoord_t vga_x;
   ycoord_t vga_y;
   colour_t vga_colour;
   logic    plot;
   logic    busy;
   logic    done;

   modport master (
      output start, x_position, y_position, width, colour,
      input  vga_x, vga_y, vga_colour, plot, busy, done
   );

   modport slave (
      input  start, x_position, y_position, width, colour,
      output vga_x, vga_y, vga_colour, plot, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/block_renderer_rect_scanner.sv
// ============================================================================
// Module : rect_scanner
// Brief  : Row-major column/row offset generator for a width x height box.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rect_scanner
   import block_renderer_pkg::*;
(
   input  wire logic    clk,
   input  wire logic    resetn,
   input  wire logic    clear,
   input  wire logic    advance,
   input  wire xcoord_t width,
   input  wire ycoord_t height,
   output logic         last,
   output xcoord_t      next_col,
   output ycoord_t      next_row
);

   xcoord_t r_col;
   ycoord_t r_row;
   logic    w_col_end;

   assign w_col_end = (r_col == width - 8'd1);
   assign last      = w_col_end && (r_row == height - 7'd1);

   // Offsets the counters will hold next cycle; the caller registers its
   // pixel address from these so the address lines up with the scan slot.
   always_comb begin
      next_col = r_col;
      next_row = r_row;
      if (clear) begin
         next_col = '0;
         next_row = '0;
      end else if (advance) begin
         if (w_col_end) begin
            next_col = '0;
            next_row = r_row + 7'd1;
         end else begin
            next_col = r_col + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col <= '0;
         r_row <= '0;
      end else begin
         r_col <= next_col;
         r_row <= next_row;
      end
   end

endmodule

`default_nettype wire

// File: rtl/block_renderer.sv
// ============================================================================
// Module : block_renderer
// Brief  : Erases the previous block and paints the new one, one pixel per
//          clock, into the VGA adapter's plot port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module block_renderer #(
   parameter int         BLOCK_H   = 4,
   parameter int         X_SCREEN  = block_renderer_pkg::X_SCREEN,
   parameter logic [2:0] BG_COLOUR = block_renderer_pkg::BG_COLOUR
) (
   input  wire logic        clk,
   input  wire logic        resetn,
   block_renderer_if.slave  bus
);
   import block_renderer_pkg::*;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ERASE = 2'd1,
      S_DRAW  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t  r_state;
   state_t  w_next_state;

   xcoord_t r_new_x;
   ycoord_t r_new_y;
   xcoord_t r_new_width;
   colour_t r_new_colour;
   xcoord_t r_prev_x;
   ycoord_t r_prev_y;
   xcoord_t r_prev_width;
   logic    r_prev_valid;

   xcoord_t r_vga_x;
   ycoord_t r_vga_y;
   colour_t r_vga_colour;
   logic    r_plot;
   logic    r_busy;
   logic    r_done;

   logic    w_clear;
   logic    w_advance;
   logic    w_load;
   logic    w_commit;
   logic    w_last;
   logic    w_scan;
   xcoord_t w_scan_width;
   xcoord_t w_next_col;
   ycoord_t w_next_row;
   xcoord_t w_src_x;
   ycoord_t w_src_y;
   colour_t w_src_colour;
   xcoord_t w_base_x;
   ycoord_t w_base_y;
   colour_t w_pix_colour;
   logic [8:0] w_col_sum;
   ycoord_t    w_row_sum;

   rect_scanner u_scanner (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (w_clear),
      .advance  (w_advance),
      .width    (w_scan_width),
      .height   (7'(BLOCK_H)),
      .last     (w_last),
      .next_col (w_next_col),
      .next_row (w_next_row)
   );

   assign w_scan_width = (r_state == S_ERASE) ? r_prev_width : r_new_width;

   always_comb begin
      w_next_state = r_state;
      w_clear      = 1'b0;
      w_advance    = 1'b0;
      w_load       = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load  = 1'b1;
               w_clear = 1'b1;
               if (r_prev_valid && (r_prev_width != '0))
                  w_next_state = S_ERASE;
               else if (bus.width != '0)
                  w_next_state = S_DRAW;
               else
                  w_next_state = S_DONE;
            end
         end
         S_ERASE: begin
            if (w_last) begin
               w_clear      = 1'b1;
               w_next_state = (r_new_width != '0) ? S_DRAW : S_DONE;
            end else begin
               w_advance = 1'b1;
            end
         end
         S_DRAW: begin
            if (w_last) begin
               w_clear      = 1'b1;
               w_next_state = S_DONE;
            end else begin
               w_advance = 1'b1;
            end
         end
         S_DONE: begin
            w_commit     = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // In IDLE the request is still on the inputs; the first pixel is built
   // from them in the same cycle the latches capture them.
   assign w_src_x      = (r_state == S_IDLE) ? bus.x_position : r_new_x;
   assign w_src_y      = (r_state == S_IDLE) ? bus.y_position : r_new_y;
   assign w_src_colour = (r_state == S_IDLE) ? bus.colour     : r_new_colour;

   always_comb begin
      w_base_x     = '0;
      w_base_y     = '0;
      w_pix_colour = '0;
      w_scan       = 1'b0;
      case (w_next_state)
         S_ERASE: begin
            w_base_x     = r_prev_x;
            w_base_y     = r_prev_y;
            w_pix_colour = BG_COLOUR;
            w_scan       = 1'b1;
         end
         S_DRAW: begin
            w_base_x     = w_src_x;
            w_base_y     = w_src_y;
            w_pix_colour = w_src_colour;
            w_scan       = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_col_sum = col_sum(w_base_x, w_next_col);
   assign w_row_sum = w_base_y + w_next_row;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_new_x      <= '0;
         r_new_y      <= '0;
         r_new_width  <= '0;
         r_new_colour <= '0;
         r_prev_x     <= '0;
         r_prev_y     <= '0;
         r_prev_width <= '0;
         r_prev_valid <= 1'b0;
      end else begin
         if (w_load) begin
            r_new_x      <= bus.x_position;
            r_new_y      <= bus.y_position;
            r_new_width  <= bus.width;
            r_new_colour <= bus.colour;
         end
         if (w_commit) begin
            r_prev_x     <= r_new_x;
            r_prev_y     <= r_new_y;
            r_prev_width <= r_new_width;
            r_prev_valid <= 1'b1;
         end
      end
   end

   // Clipped columns still occupy their slot; only the write enable drops.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_vga_x      <= '0;
         r_vga_y      <= '0;
         r_vga_colour <= '0;
         r_plot       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_vga_x      <= w_scan ? w_col_sum[7:0] : '0;
         r_vga_y      <= w_scan ? w_row_sum      : '0;
         r_vga_colour <= w_scan ? w_pix_colour   : '0;
         r_plot       <= w_scan && (w_col_sum < 9'(X_SCREEN));
         r_busy       <= (w_next_state != S_IDLE);
         r_done       <= (w_next_state == S_DONE);
      end
   end

   assign bus.vga_x      = r_vga_x;
   assign bus.vga_y      = r_vga_y;
   assign bus.vga_colour = r_vga_colour;
   assign bus.plot       = r_plot;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_block_renderer.sv
// ============================================================================
// Module : tb_block_renderer
// Brief  : Randomised redraw bench for block_renderer with a pixel-list model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_block_renderer;

   localparam int H  = 4;
   localparam int XS = 160;

   logic clk = 1'b0;
   logic resetn;

   block_renderer_if bif();

   block_renderer #(
      .BLOCK_H   (4),
      .X_SCREEN  (160),
      .BG_COLOUR (3'b000)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int m_prev_x;
   int m_prev_y;
   int m_prev_w;
   bit m_prev_valid;

   // Each slot: {busy, done, plot, x, y, colour}; address fields zero when plot=0.
   logic [20:0] exp_q[$];

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [20:0] pix(input bit plot, input int x, input int y, input int c);
      if (!plot) return {3'b100, 18'd0};
      return {3'b101, 8'(x), 7'(y), 3'(c)};
   endfunction

   function automatic logic [20:0] obs_word();
      if (bif.plot === 1'b1)
         return {bif.busy, bif.done, 1'b1, bif.vga_x, bif.vga_y, bif.vga_colour};
      return {bif.busy, bif.done, bif.plot, 18'd0};
   endfunction

   function automatic logic [20:0] raw_word();
      return {bif.busy, bif.done, bif.plot, bif.vga_x, bif.vga_y, bif.vga_colour};
   endfunction

   task automatic build_rect(input int bx, input int by, input int w, input int c);
      for (int r = 0; r < H; r++) begin
         for (int cc = 0; cc < w; cc++) begin
            int px = bx + cc;
            int py = (by + r) % 128;
            exp_q.push_back(pix(px < XS, px, py, c));
         end
      end
   endtask

   task automatic drive_inputs(input int x, input int y, input int w, input int c);
      bif.x_position = 8'(x);
      bif.y_position = 7'(y);
      bif.width      = 8'(w);
      bif.colour     = 3'(c);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      check_value("reset_idle", 32'(raw_word()), 32'd0);
      resetn = 1'b1;
      m_prev_valid = 1'b0;
   endtask

   // abort_at >= 0 drops resetn asynchronously during that slot.
   task automatic redraw(input int x, input int y, input int w, input int c,
                         input bit noise, input int abort_at);
      exp_q.delete();
      if (m_prev_valid && m_prev_w != 0) build_rect(m_prev_x, m_prev_y, m_prev_w, 0);
      build_rect(x, y, w, c);

      @(negedge clk);
      bif.start = 1'b1;
      drive_inputs(x, y, w, c);

      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         if (k == abort_at) begin
            #3 resetn = 1'b0;
            #1 check_value("async_reset", 32'(raw_word()), 32'd0);
            bif.start = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            m_prev_valid = 1'b0;
            return;
         end
         check_value($sformatf("pix%0d", k), 32'(obs_word()), 32'(exp_q[k]));
         if (noise) begin
            bif.start = 1'($urandom_range(0, 1));
            drive_inputs($urandom_range(0, 159), $urandom_range(0, 127),
                         $urandom_range(0, 255), $urandom_range(0, 7));
         end else begin
            bif.start = 1'b0;
         end
      end

      @(negedge clk);
      check_value("done", 32'(obs_word()), 32'({3'b110, 18'd0}));
      bif.start = 1'b0;
      @(negedge clk);
      check_value("idle", 32'(obs_word()), 32'd0);

      m_prev_valid = 1'b1;
      m_prev_x     = x;
      m_prev_y     = y;
      m_prev_w     = w;
   endtask

   initial begin
      resetn       = 1'b0;
      bif.start    = 1'b0;
      drive_inputs(0, 0, 0, 0);
      m_prev_valid = 1'b0;
      m_prev_x     = 0;
      m_prev_y     = 0;
      m_prev_w     = 0;

      repeat (2) @(negedge clk);
      check_value("reset_outputs", 32'(raw_word()), 32'd0);
      resetn = 1'b1;

      redraw(10, 20, 3, 4, 1'b0, -1);
      redraw(11, 20, 3, 4, 1'b0, -1);
      redraw(158, 20, 4, 2, 1'b0, -1);

      apply_reset();
      redraw(5, 5, 0, 1, 1'b0, -1);
      redraw(30, 40, 2, 5, 1'b0, -1);

      redraw(50, 60, 6, 3, 1'b1, -1);

      // 24 erase slots precede the draw, so slot 30 lands mid-DRAW.
      redraw(20, 30, 5, 7, 1'b0, 30);
      redraw(40, 50, 3, 6, 1'b0, -1);

      for (int i = 0; i < 16; i++) begin
         redraw($urandom_range(0, 159), $urandom_range(0, 116), $urandom_range(0, 24),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/block_renderer.md
# block_renderer

Pixel writer that consumes the moving block's coordinates and paints it into the VGA adapter's frame buffer. On each position update it erases the previously drawn rectangle with the background colour, then draws the new one, emitting one pixel per clock on the adapter's plot interface. It sits between the position registers (x/y of the active block) and the VGA adapter, and is retriggered once per sync tick.

## Interface
- BLOCK_H, 4: block height in pixel rows.
- X_SCREEN, 160: screen width; columns at or beyond this are never plotted.
- BG_COLOUR, 3'b000: colour used for erase.
- clk  in  1  system clock (50 MHz), all state updates on posedge.
- resetn  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle request to redraw; sampled only in IDLE.
- x_position  in  8  left column of new block (0..144).
- y_position  in  7  top row of new block.
- width  in  8  block width in pixels (0 allowed).
- colour  in  3  block colour.
- vga_x  out  8  pixel column to adapter.
- vga_y  out  7  pixel row to adapter.
- vga_colour  out  3  pixel colour to adapter.
- plot  out  1  write-enable to adapter, valid with vga_x/y/colour in the same cycle.
- busy  out  1  high from cycle after accepted start until done.
- done  out  1  one-cycle pulse when the redraw completes.

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- IDLE: start=1 latches x_position, y_position, width, colour into "new" registers; busy rises next cycle. Next state ERASE if prev_valid=1 and prev width ≠ 0, else DRAW (if new width ≠ 0) or DONE.
- ERASE: scan prev rectangle (prev_x, prev_y, prev_width × BLOCK_H) row-major, column counter inner; vga_colour=BG_COLOUR. After last pixel → DRAW (new width ≠ 0) or DONE.
- DRAW: scan new rectangle identically with latched colour. After last pixel → DONE.
- DONE: done=1 for one cycle; copy new → prev registers, set prev_valid=1; → IDLE; busy falls.
- Pixel address = base + offset; column sum computed 9 bits wide; plot=0 when sum ≥ X_SCREEN (pixel slot still consumed, so cycle count is independent of clipping). Row sum 7 bits, wraps modulo 128 (caller keeps y+BLOCK_H ≤ 120).
- start while busy: ignored, no queueing.
- Inputs x_position..colour only sampled on accepted start; changes during a redraw have no effect.
- Reset (any time, including mid-scan): state IDLE, plot=0, done=0, busy=0, vga_x=0, vga_y=0, vga_colour=0, all counters 0, prev_valid=0 (first redraw after reset performs no erase).

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: busy=1, first pixel presented (plot registered with address/colour).
- ERASE length = prev_width × BLOCK_H cycles; DRAW length = width × BLOCK_H cycles; DONE 1 cycle.
- Total from start to done pulse = 1 + erase + draw cycles; done at that cycle, IDLE (start accepted) the cycle after.
- Worst case (width 144, H 4): 1 + 576 + 576 = 1153 cycles, well within one sync period.
- Outputs are registered; no combinational path from inputs to plot.

## Structure
- Shared package: X_SCREEN (160), Y_SCREEN (120), X_MAX (144), colour width (3), BG_COLOUR; same constants used by the position registers.
- State enumeration local to this block.
- One sub-module: rect_scanner — clear/advance inputs, width and height limits, outputs column/row offsets and a last flag; instantiated once and reused for ERASE and DRAW.

## Test plan
- Reset then start with x=10, y=20, width=3, colour=3'b100 → no erase; 12 plot cycles covering (10..12, 20..23) in row-major order with colour 100; done on cycle 13.
- Second start with x=11, same y/width → 12 erase pixels at (10..12, 20..23) colour 000, then 12 draw pixels at (11..13), done at cycle 25.
- x=158, width=4 → pixels at columns 158,159 plotted; columns 160,161 with plot=0; cycle count unchanged (16 draw cycles).
- width=0 after reset → no plot pulses, done on cycle 1; next start with width=2 performs no erase.
- start asserted repeatedly during busy, inputs changed mid-draw → ignored; drawn pixels match values latched at accepted start.
- resetn dropped mid-DRAW → outputs go to 0 immediately (asynchronously); next start performs no erase.
